prng_stream: RTL and testbench
==============================

Name: prng_stream

Overview:
- Parametrised successor to the current 8-bit PRNG: Galois LFSR of configurable width and polynomial.
- Delivers bursts of 1..2^LEN_W-1 pseudo-random words over a valid/ready stream with a last flag.
- Supports run-time reseeding that can abort a burst in progress.
- Sits between the control logic, which issues requests and seeds, and any consumer that packs output words, e.g. a 4-beat byte-to-32-bit packer.

Parameters:
- LFSR_W, 32, LFSR state width; must be >= OUT_W.
- OUT_W, 8, output word width: the low OUT_W bits of the state.
- TAPS, 32'h80200003, Galois feedback mask (x^32+x^22+x^2+x+1).
- SEED, 32'h02468ACD, reset seed; also substituted for any zero seed_in.
- LEN_W, 4, width of req_len.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  burst request pulse; sampled only in IDLE.
- req_len  in  LEN_W  number of words in the burst; 0 means the request is ignored.
- seed_load  in  1  load a new seed; aborts any burst.
- seed_in  in  LFSR_W  new seed value.
- busy  out  1  high while in BURST.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  OUT_W  random word.
- out_last  out  1  marks the final word of the burst.

Behaviour:
- Step function: step(s) = s[0] ? (s>>1)^TAPS : s>>1. The state advances exactly once per issued word, never otherwise.
- Reset (async assert, sync release by the system): state=SEED, FSM=IDLE, busy=0, out_valid=0, out_data=0, out_last=0, remaining count=0.
- FSM states: IDLE, BURST.
- IDLE + req + req_len!=0 + !seed_load:
  - Next cycle: state=step(state), out_data=step(state)[OUT_W-1:0], out_valid=1.
  - out_last=(req_len==1), remaining=req_len-1, busy=1, FSM=BURST.
  - Latency: 1 cycle from req to first valid word.
- BURST, handshake (out_valid & out_ready):
  - If !out_last: state advances, out_data takes the new low bits, remaining decrements, out_last=(remaining==1).
  - If out_last: out_valid=0, out_last=0, busy=0, FSM=IDLE next cycle. The state is not advanced, so the last word's state is retained.
- BURST, !out_ready: out_data, out_last and state hold stable. The sequence is independent of back-pressure.
- req while busy is ignored and not queued. The earliest new req is accepted the cycle after busy falls.
- seed_load, any state, highest priority:
  - Next cycle: state = (seed_in==0) ? SEED : seed_in.
  - FSM=IDLE, out_valid=0, out_last=0, busy=0.
  - A req in the same cycle is dropped.
  - The next burst's first word is step(new seed).
- Mid-burst rst: immediate return to reset values. The sequence restarts from SEED, so the first word after reset equals the first word after power-up.
- Counter width is LEN_W; remaining never underflows because the burst ends on the last beat.
- out_data is a registered output with no combinational path from inputs.

Decomposition:
- Package prng_pkg holds:
  - default constants PRNG_SEED=32'h02468ACD and PRNG_TAPS=32'h80200003;
  - FSM state enum {IDLE, BURST};
  - the function lfsr_step (shared with future bench models).
- One sub-module, prng_lfsr_core: the state register plus step/load logic, with inputs adv, load and load_val. prng_stream wraps it with the FSM, counter and output registers.

Test Plan:
- Reset, then req with req_len=4 and out_ready=1 throughout:
  - words 0x65, 0xB1, 0x5B, 0xAE on four consecutive cycles starting 1 cycle after req;
  - out_last only on 0xAE; packed little-endian the burst is 0xAE5BB165;
  - busy falls the cycle after the last beat.
- Same burst with out_ready toggling 1,0,0,1,0,1,1:
  - identical word sequence 65,B1,5B,AE;
  - out_data and out_last stable during stalls.
- Reset asserted after the 2nd word of a burst, then req_len=4:
  - out_valid=0 immediately;
  - after release the burst again yields 65,B1,5B,AE.
- seed_load with seed_in=0, then req_len=1: word is 0x65 (SEED substituted). A req issued in the same cycle as seed_load produces no output.
- req_len=0 produces no valid. A req during BURST is ignored: a 2-word burst yields exactly 2 words, then IDLE.
- Back-to-back bursts of len 2 then len 2, second req issued the cycle busy falls: words 65,B1 then 5B,AE, showing the sequence continues across bursts.

Source files
------------

// File: rtl/prng_pkg.sv
// prng_pkg: shared constants, FSM state type and LFSR step helper for the
// prng_stream block.
//   PRNG_SEED  - default reset seed (also replaces any all-zero seed)
//   PRNG_TAPS  - default Galois feedback mask, x^32+x^22+x^2+x+1
//   prng_st_e  - burst FSM state encoding
//   lfsr_step  - one Galois LFSR step on a zero-extended state
package prng_pkg;

  localparam logic [31:0] PRNG_SEED  = 32'h02468ACD;
  localparam logic [31:0] PRNG_TAPS  = 32'h80200003;
  localparam int          LFSR_MAX_W = 64;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } prng_st_e;

  // Works on a zero-extended state so one function serves every width; the
  // caller truncates the result back to its own width.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
    input logic [LFSR_MAX_W-1:0] s,
    input logic [LFSR_MAX_W-1:0] taps
  );
    logic [LFSR_MAX_W-1:0] r;
    if (s[0]) begin
      r = (s >> 1) ^ taps;
    end else begin
      r = s >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/prng_stream_if.sv
// prng_stream_if: request/seed/stream bundle for prng_stream.
//   req, req_len          - burst request and its length (controller -> PRNG)
//   seed_load, seed_in    - run-time reseed (controller -> PRNG)
//   busy                  - burst in progress (PRNG -> controller)
//   out_valid/out_ready   - stream handshake
//   out_data, out_last    - random word and end-of-burst marker
// Modports: master = controller/consumer side, slave = the PRNG.
interface prng_stream_if #(
  parameter int LFSR_W = 32,
  parameter int OUT_W  = 8,
  parameter int LEN_W  = 4
);
  logic              req;
  logic [LEN_W-1:0]  req_len;
  logic              seed_load;
  logic [LFSR_W-1:0] seed_in;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_last;

  modport master (
    output req, req_len, seed_load, seed_in, out_ready,
    input  busy, out_valid, out_data, out_last
  );

  modport slave (
    input  req, req_len, seed_load, seed_in, out_ready,
    output busy, out_valid, out_data, out_last
  );
endinterface

// File: rtl/prng_lfsr_core.sv
// prng_lfsr_core: Galois LFSR state register.
//   clk, rst   - clock and asynchronous active-high reset (state -> SEED)
//   adv        - advance the state by one step
//   load       - load load_val (SEED if load_val is zero); wins over adv
//   load_val   - seed to load
//   step_val   - combinational step(state), the value adv would store
module prng_lfsr_core
  import prng_pkg::*;
#(
  parameter int                LFSR_W = 32,
  parameter logic [LFSR_W-1:0] TAPS   = PRNG_TAPS,
  parameter logic [LFSR_W-1:0] SEED   = PRNG_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] step_val
);

  logic [LFSR_W-1:0] state_r;
  logic [LFSR_W-1:0] seed_s;

  // An all-zero state would lock the LFSR, so a zero seed is replaced.
  assign seed_s   = (load_val == {LFSR_W{1'b0}}) ? SEED : load_val;
  assign step_val = LFSR_W'(lfsr_step(LFSR_MAX_W'(state_r), LFSR_MAX_W'(TAPS)));

  // State register: load has priority over advance; otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= SEED;
    end else if (load) begin
      state_r <= seed_s;
    end else if (adv) begin
      state_r <= step_val;
    end else begin
      state_r <= state_r;
    end
  end

endmodule

// File: rtl/prng_stream.sv
// prng_stream: burst PRNG with valid/ready output stream.
//   clk, rst - clock and asynchronous active-high reset
//   bus      - prng_stream_if slave: req/req_len start a burst of req_len
//              words, seed_load/seed_in reseed (aborting any burst), words
//              leave on out_data/out_valid/out_ready with out_last on the
//              final word; busy is high while a burst is in progress.
// All outputs are registered. The LFSR advances once per issued word only,
// so the word sequence does not depend on back-pressure.
module prng_stream
  import prng_pkg::*;
#(
  parameter int                LFSR_W = 32,
  parameter int                OUT_W  = 8,
  parameter logic [LFSR_W-1:0] TAPS   = PRNG_TAPS,
  parameter logic [LFSR_W-1:0] SEED   = PRNG_SEED,
  parameter int                LEN_W  = 4
) (
  input  logic          clk,
  input  logic          rst,
  prng_stream_if.slave  bus
);

  prng_st_e          fsm_r, fsm_nxt_s;
  logic              valid_r, valid_nxt_s;
  logic              last_r, last_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic [LEN_W-1:0]  rem_r, rem_nxt_s;
  logic [OUT_W-1:0]  data_r, data_nxt_s;
  logic              adv_s;
  logic [LFSR_W-1:0] step_s;

  prng_lfsr_core #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .SEED   (SEED)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .adv      (adv_s),
    .load     (bus.seed_load),
    .load_val (bus.seed_in),
    .step_val (step_s)
  );

  // Next-state and output decode; seed_load overrides everything.
  always_comb begin
    fsm_nxt_s   = fsm_r;
    valid_nxt_s = valid_r;
    last_nxt_s  = last_r;
    busy_nxt_s  = busy_r;
    rem_nxt_s   = rem_r;
    data_nxt_s  = data_r;
    adv_s       = 1'b0;
    if (bus.seed_load) begin
      fsm_nxt_s   = IDLE;
      valid_nxt_s = 1'b0;
      last_nxt_s  = 1'b0;
      busy_nxt_s  = 1'b0;
    end else begin
      case (fsm_r)
        IDLE: begin
          if (bus.req && (bus.req_len != {LEN_W{1'b0}})) begin
            adv_s       = 1'b1;
            data_nxt_s  = step_s[OUT_W-1:0];
            valid_nxt_s = 1'b1;
            last_nxt_s  = (bus.req_len == LEN_W'(1));
            rem_nxt_s   = bus.req_len - LEN_W'(1);
            busy_nxt_s  = 1'b1;
            fsm_nxt_s   = BURST;
          end else begin
            adv_s = 1'b0;
          end
        end
        BURST: begin
          if (valid_r && bus.out_ready) begin
            if (last_r) begin
              // Final beat taken: state is left on the last word's value.
              valid_nxt_s = 1'b0;
              last_nxt_s  = 1'b0;
              busy_nxt_s  = 1'b0;
              fsm_nxt_s   = IDLE;
            end else begin
              adv_s      = 1'b1;
              data_nxt_s = step_s[OUT_W-1:0];
              rem_nxt_s  = rem_r - LEN_W'(1);
              // rem_r counts words still to come after the current one.
              last_nxt_s = (rem_r == LEN_W'(1));
            end
          end else begin
            adv_s = 1'b0;
          end
        end
        default: begin
          fsm_nxt_s   = IDLE;
          valid_nxt_s = 1'b0;
          last_nxt_s  = 1'b0;
          busy_nxt_s  = 1'b0;
        end
      endcase
    end
  end

  // FSM, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_r   <= IDLE;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
      rem_r   <= {LEN_W{1'b0}};
      data_r  <= {OUT_W{1'b0}};
    end else begin
      fsm_r   <= fsm_nxt_s;
      valid_r <= valid_nxt_s;
      last_r  <= last_nxt_s;
      busy_r  <= busy_nxt_s;
      rem_r   <= rem_nxt_s;
      data_r  <= data_nxt_s;
    end
  end

  assign bus.busy      = busy_r;
  assign bus.out_valid = valid_r;
  assign bus.out_last  = last_r;
  assign bus.out_data  = data_r;

endmodule

// File: tb/tb_prng_stream.sv
// tb_prng_stream: self-checking bench for prng_stream. A queue-based model
// pre-computes every word of an accepted burst and checks the DUT outputs
// each cycle; directed scenarios plus a randomized phase.
module tb_prng_stream;

  localparam logic [31:0] M_SEED = 32'h02468ACD;
  localparam logic [31:0] M_TAPS = 32'h80200003;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  prng_stream_if #(.LFSR_W(32), .OUT_W(8), .LEN_W(4)) bus ();

  prng_stream #(
    .LFSR_W (32),
    .OUT_W  (8),
    .TAPS   (M_TAPS),
    .SEED   (M_SEED),
    .LEN_W  (4)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] m_state;
  logic [7:0]  m_q[$];
  logic [7:0]  got_q[$];
  logic        pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_next(input logic [31:0] s);
    if ((s % 32'd2) == 32'd1) return (s / 32'd2) ^ M_TAPS;
    else return s / 32'd2;
  endfunction

  task automatic m_reset();
    m_state = M_SEED;
    m_q.delete();
  endtask

  // Model reaction to one rising edge, given the inputs held across it.
  task automatic m_clock();
    if (rst) begin
      m_reset();
    end else if (bus.seed_load) begin
      m_q.delete();
      m_state = (bus.seed_in == 32'd0) ? M_SEED : bus.seed_in;
    end else if (m_q.size() > 0) begin
      if (bus.out_ready) void'(m_q.pop_front());
    end else if (bus.req && bus.req_len != 4'd0) begin
      for (int i = 0; i < int'(bus.req_len); i++) begin
        m_state = m_next(m_state);
        m_q.push_back(m_state[7:0]);
      end
    end
  endtask

  task automatic cycle(input string tag);
    @(negedge clk);
    check_eq({tag, ":valid"}, 64'(bus.out_valid), 64'(m_q.size() > 0));
    check_eq({tag, ":busy"}, 64'(bus.busy), 64'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check_eq({tag, ":data"}, 64'(bus.out_data), 64'(m_q[0]));
      check_eq({tag, ":last"}, 64'(bus.out_last), 64'(m_q.size() == 1));
    end else begin
      check_eq({tag, ":last"}, 64'(bus.out_last), 64'd0);
    end
    if (bus.out_valid && bus.out_ready && !rst) got_q.push_back(bus.out_data);
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic idle_inputs();
    bus.req       = 1'b0;
    bus.req_len   = 4'd0;
    bus.seed_load = 1'b0;
    bus.seed_in   = 32'd0;
    bus.out_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_reset();
    cycle("rst");
    cycle("rst");
    rst = 1'b0;
  endtask

  task automatic start(input logic [3:0] len);
    bus.req     = 1'b1;
    bus.req_len = len;
  endtask

  task automatic check_std_burst(input string tag);
    logic [31:0] packed_w;
    check_eq({tag, ":nwords"}, 64'(got_q.size()), 64'd4);
    packed_w = 32'd0;
    if (got_q.size() == 4) packed_w = {got_q[3], got_q[2], got_q[1], got_q[0]};
    check_eq({tag, ":packed"}, 64'(packed_w), 64'h00000000AE5BB165);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    m_reset();
    @(negedge clk);
    check_eq("reset:data", 64'(bus.out_data), 64'd0);
    check_eq("reset:valid", 64'(bus.out_valid), 64'd0);
    check_eq("reset:last", 64'(bus.out_last), 64'd0);
    check_eq("reset:busy", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic 4-word burst, consumer always ready.
    got_q.delete();
    start(4'd4);
    cycle("t1");
    idle_inputs();
    repeat (5) cycle("t1");
    check_std_burst("t1");

    // Same burst with back-pressure.
    do_reset();
    got_q.delete();
    start(4'd4);
    cycle("t2");
    idle_inputs();
    for (int i = 0; i < 7; i++) begin
      bus.out_ready = pat[i];
      cycle("t2");
    end
    bus.out_ready = 1'b1;
    cycle("t2");
    check_std_burst("t2");

    // Reset in the middle of a burst.
    do_reset();
    start(4'd4);
    cycle("t3");
    idle_inputs();
    cycle("t3");
    cycle("t3");
    rst = 1'b1;
    #1;
    check_eq("t3:abort_valid", 64'(bus.out_valid), 64'd0);
    m_reset();
    cycle("t3rst");
    rst = 1'b0;
    got_q.delete();
    start(4'd4);
    cycle("t3");
    idle_inputs();
    repeat (5) cycle("t3");
    check_std_burst("t3");

    // Zero seed with a simultaneous req, then a single-word burst.
    got_q.delete();
    start(4'd4);
    bus.seed_load = 1'b1;
    bus.seed_in   = 32'd0;
    cycle("t4");
    idle_inputs();
    cycle("t4");
    cycle("t4");
    check_eq("t4:dropped", 64'(got_q.size()), 64'd0);
    start(4'd1);
    cycle("t4");
    idle_inputs();
    cycle("t4");
    cycle("t4");
    check_eq("t4:nwords", 64'(got_q.size()), 64'd1);
    if (got_q.size() == 1) check_eq("t4:word", 64'(got_q[0]), 64'h65);

    // Zero length, then a req raised during a 2-word burst.
    got_q.delete();
    start(4'd0);
    cycle("t5");
    idle_inputs();
    cycle("t5");
    start(4'd2);
    cycle("t5");
    start(4'd3);
    cycle("t5");
    idle_inputs();
    repeat (3) cycle("t5");
    check_eq("t5:nwords", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) check_eq("t5:words", 64'({got_q[1], got_q[0]}), 64'h5BB1);

    // Back-to-back bursts, second req the cycle busy falls.
    do_reset();
    got_q.delete();
    start(4'd2);
    cycle("t6");
    idle_inputs();
    cycle("t6");
    cycle("t6");
    check_eq("t6:busy_fell", 64'(bus.busy), 64'd0);
    start(4'd2);
    cycle("t6");
    idle_inputs();
    repeat (3) cycle("t6");
    check_std_burst("t6");

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      bus.req       = ($urandom % 4) == 0;
      bus.req_len   = 4'($urandom_range(15, 0));
      bus.out_ready = ($urandom % 3) != 0;
      bus.seed_load = ($urandom % 40) == 0;
      bus.seed_in   = (($urandom % 4) == 0) ? 32'd0 : $urandom;
      if (($urandom % 250) == 0) begin
        rst = 1'b1;
        m_reset();
      end else begin
        rst = 1'b0;
      end
      cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
